// File: rtl/echo_delay_ctrl.sv
// Echo delay-line sequencer: one tap read and one sample write per input sample
// against an external registered single-port RAM, with circular pointers and fill gating.
module echo_delay_ctrl #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 24,
  parameter int DEFAULT_DELAY = 12000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] audio_in,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              delay_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tap_out,
  output logic              tap_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] DEF_DLY = ADDR_W'(DEFAULT_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_delay_act;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_val;
  logic [DATA_W-1:0] r_samp;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_tap_out;
  logic              r_tap_valid;
  logic              r_busy;
  logic              r_overrun;

  logic [ADDR_W-1:0] w_dl_clamp;
  logic              w_apply;
  logic [ADDR_W-1:0] w_new_dly;
  logic [ADDR_W-1:0] w_dly_eff;
  logic              w_filled;

  // A load in the same IDLE cycle wins over a pending value.
  assign w_dl_clamp = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  assign w_apply    = delay_load | r_pend;
  assign w_new_dly  = delay_load ? w_dl_clamp : r_pend_val;
  assign w_dly_eff  = w_apply ? w_new_dly : r_delay_act;
  assign w_filled   = (r_fill_cnt >= r_delay_act);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_delay_act <= DEF_DLY;
      r_fill_cnt  <= '0;
      r_pend      <= 1'b0;
      r_pend_val  <= '0;
      r_samp      <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_tap_out   <= '0;
      r_tap_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tap_valid <= 1'b0;
      if (r_state != S_IDLE) begin
        if (valid) r_overrun <= 1'b1;
        if (delay_load) begin
          r_pend     <= 1'b1;
          r_pend_val <= w_dl_clamp;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_apply) begin
            r_delay_act <= w_new_dly;
            r_pend      <= 1'b0;
            r_fill_cnt  <= '0;
          end
          if (valid) begin
            r_samp     <= audio_in;
            r_ram_addr <= r_wr_ptr - w_dly_eff;
            r_ram_we   <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          r_ram_addr  <= r_wr_ptr;
          r_ram_we    <= 1'b1;
          r_ram_wdata <= r_samp;
          r_state     <= S_WR;
        end
        S_WR: begin
          // Read data for the RD address is on ram_rdata during this cycle.
          r_tap_out   <= w_filled ? ram_rdata : '0;
          r_tap_valid <= 1'b1;
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          if (!w_filled) r_fill_cnt <= r_fill_cnt + 1'b1;
          r_ram_we    <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign tap_out   = r_tap_out;
  assign tap_valid = r_tap_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: sample-history model predicts a per-cycle output
// timeline, checked every cycle, plus literal tap sequences per scenario.
module tb_echo_delay_ctrl;
  localparam int AW = 4;
  localparam int DW = 24;
  localparam int DEF = 4;
  localparam int NC = 2048;
  localparam int BIG = 1 << 30;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] audio_in = '0;
  logic [AW-1:0] delay_len = '0;
  logic          delay_load = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] tap_out;
  logic          tap_valid;
  logic          busy;
  logic          overrun;

  echo_delay_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEFAULT_DELAY(DEF)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .audio_in(audio_in),
    .delay_len(delay_len), .delay_load(delay_load), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tap_out(tap_out), .tap_valid(tap_valid), .busy(busy), .overrun(overrun));

  always #5 clock = ~clock;

  // Registered single-port RAM, preloaded with junk that fill gating must hide.
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 24'hA00000 | DW'(i * 17 + 5);
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected output timeline, indexed by cycle number (interval after posedge k).
  bit exp_busy [NC];
  bit exp_we   [NC];
  bit exp_tv   [NC];
  bit exp_clr  [NC];
  int exp_tap  [NC];
  int exp_addr [NC];
  int exp_wd   [NC];
  int cyc = 0;
  int chk_from = BIG;
  int ovr_from = BIG;
  int cur_tap = 0;
  int last_rd = -1;
  int obs_q[$];

  // Model state: sample history since reset and delay bookkeeping.
  int hist[$];
  int d_act = DEF;
  int fill = 0;
  bit pend = 0;
  int pend_val = 0;
  int busy_until = 0;

  always @(posedge clock) begin
    cyc++;
    #1;
    if (cyc >= chk_from && cyc < NC) begin
      if (exp_clr[cyc]) cur_tap = 0;
      if (exp_tv[cyc]) cur_tap = exp_tap[cyc];
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("ram_we", 32'(ram_we), 32'(exp_we[cyc]));
      chk("tap_valid", 32'(tap_valid), 32'(exp_tv[cyc]));
      chk("tap_out", 32'(tap_out), 32'(cur_tap));
      chk("overrun", 32'(overrun), 32'(cyc >= ovr_from));
      if (exp_addr[cyc] >= 0) chk("ram_addr", 32'(ram_addr), 32'(exp_addr[cyc]));
      if (exp_wd[cyc] >= 0) chk("ram_wdata", 32'(ram_wdata), 32'(exp_wd[cyc]));
      if (tap_valid) obs_q.push_back(int'(tap_out));
      if (busy && !ram_we) last_rd = int'(ram_addr);
    end
  end

  task automatic step(input bit v, input int a, input int dl, input bit ld, input bit rst);
    int k, cl, w, tap;
    @(negedge clock);
    k = cyc;
    valid = v; audio_in = DW'(a); delay_len = AW'(dl); delay_load = ld; reset_n = !rst;
    if (rst) begin
      for (int i = k + 1; i < NC; i++) begin
        exp_busy[i] = 0; exp_we[i] = 0; exp_tv[i] = 0; exp_clr[i] = 0;
        exp_tap[i] = 0; exp_addr[i] = -1; exp_wd[i] = -1;
      end
      exp_addr[k+1] = 0; exp_wd[k+1] = 0; exp_clr[k+1] = 1;
      hist.delete(); d_act = DEF; fill = 0; pend = 0; busy_until = 0; ovr_from = BIG;
      if (chk_from > k + 1) chk_from = k + 1;
    end else begin
      cl = (dl == 0) ? 1 : dl;
      if (k >= busy_until) begin
        if (ld) begin d_act = cl; pend = 0; fill = 0; end
        else if (pend) begin d_act = pend_val; pend = 0; fill = 0; end
        if (v) begin
          w = hist.size();
          tap = (fill < d_act) ? 0 : hist[w - d_act];
          exp_busy[k+1] = 1; exp_addr[k+1] = (w - d_act) & 15;
          exp_busy[k+2] = 1; exp_we[k+2] = 1; exp_addr[k+2] = w & 15; exp_wd[k+2] = a;
          exp_tv[k+3] = 1; exp_tap[k+3] = tap;
          hist.push_back(a);
          if (fill < d_act) fill++;
          busy_until = k + 3;
        end
      end else begin
        if (ld) begin pend = 1; pend_val = cl; end
        if (v && ovr_from > k + 1) ovr_from = k + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int a, input int gap);
    step(1, a, 0, 0, 0);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    idle(1);
    obs_q.delete();
  endtask

  task automatic lit_taps(input string nm, input int exp_q[$]);
    chk({nm, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin exp_addr[i] = -1; exp_wd[i] = -1; end
    idle(1);

    // Default delay 4, valid every 4 cycles.
    do_reset();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_tap_out", 32'(tap_out), 0);
    for (int n = 1; n <= 10; n++) sample(n, 4);
    idle(2);
    lit_taps("s1", '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6});

    // Delay 15 with pointer wrap, back-to-back at 3-cycle spacing.
    do_reset();
    step(0, 0, 15, 1, 0);
    for (int n = 0; n < 20; n++) sample(100 + n, 3);
    idle(2);
    chk("s2_count", 32'(obs_q.size()), 20);
    if (obs_q.size() == 20) begin
      chk("s2_last_zero", 32'(obs_q[14]), 0);
      for (int i = 15; i < 20; i++) chk($sformatf("s2[%0d]", i), 32'(obs_q[i]), 32'(85 + i));
    end

    // Pending load captured during RD, then delay_len=0 clamps to 1.
    do_reset();
    for (int n = 1; n <= 6; n++) sample(n, 3);
    step(1, 7, 0, 0, 0);
    step(0, 0, 2, 1, 0);
    idle(1);
    for (int n = 8; n <= 10; n++) sample(n, 3);
    step(0, 0, 0, 1, 0);
    sample(11, 3);
    sample(12, 3);
    idle(2);
    lit_taps("s3", '{0, 0, 0, 0, 1, 2, 3, 0, 0, 8, 0, 11});

    // Overrun: valid 2 cycles after an accepted one.
    do_reset();
    step(1, 50, 0, 0, 0);
    idle(1);
    step(1, 51, 0, 0, 0);
    idle(3);
    chk("s4_overrun_set", 32'(overrun), 1);
    chk("s4_tap_count", 32'(obs_q.size()), 1);
    sample(52, 4);
    chk("s4_overrun_sticky", 32'(overrun), 1);
    do_reset();
    chk("s4_overrun_cleared", 32'(overrun), 0);

    // Reset landing on the WR edge discards the sample.
    for (int n = 1; n <= 6; n++) sample(n, 3);
    step(1, 77, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(1);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_tap_valid", 32'(tap_valid), 0);
    chk("s5_tap_out", 32'(tap_out), 0);
    obs_q.delete();
    for (int n = 1; n <= 5; n++) sample(n, 3);
    idle(2);
    lit_taps("s5", '{0, 0, 0, 0, 1});

    // Load coincident with valid in IDLE applies to that sample.
    obs_q.delete();
    step(1, 9, 3, 1, 0);
    idle(4);
    chk("s6_rd_addr", 32'(last_rd), 2);
    lit_taps("s6", '{0});

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
